joy_serial_rx: RTL and testbench

JOY_SERIAL_RX -- requirements
Module: joy_serial_rx

---
 rtl/joy_serial_pkg.sv | 35 +++
 rtl/joy_sync2.sv | 26 ++
 rtl/joy_serial_rx.sv | 143 ++++++++++++++
 tb/tb_joy_serial_rx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/joy_serial_pkg.sv
// rtl/joy_serial_pkg.sv - shared types and constants for the serial joystick receiver
package joy_serial_pkg;

  localparam int FRAME_BITS      = 24;
  localparam int BITS_PER_PLAYER = 12;

  localparam int BTN_RIGHT = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_UP    = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_D     = 7;
  localparam int BTN_E     = 8;
  localparam int BTN_F     = 9;
  localparam int BTN_S     = 10;
  localparam int BTN_LB    = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_LO,
    ST_LOAD_HI,
    ST_CLK_LO,
    ST_CLK_HI,
    ST_COMMIT,
    ST_GAP_WAIT
  } joy_state_e;

  // Player buttons occupy [11:0]; the upper nibble of the output word is always zero.
  function automatic logic [15:0] player_word(input logic [BITS_PER_PLAYER-1:0] btn);
    return {4'h0, btn};
  endfunction

endpackage

// File: rtl/joy_sync2.sv
// rtl/joy_sync2.sv - two-flop synchronizer with asynchronous active-high reset
module joy_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/joy_serial_rx.sv
// rtl/joy_serial_rx.sv - serial joystick adapter receiver, 24-bit frame, two players
// Optional debouncing of whole frames with macro JOY_SERIAL_RX_DEBOUNCE_EN.
module joy_serial_rx
  import joy_serial_pkg::*;
#(
  parameter int DIV = 24,
  parameter int GAP = 4800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        JOY_DATA,
  output logic        JOY_CLK,
  output logic        JOY_LOAD,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_done
);

  localparam int MAXC = (DIV > GAP) ? DIV : GAP;
  localparam int PW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] GAP_LAST = PW'(GAP - 1);
  localparam logic [4:0]    LAST_BIT = 5'(FRAME_BITS - 1);

  if (DIV < 4 || GAP < 1) begin : g_param_check
    $error("joy_serial_rx: DIV must be >= 4 and GAP must be >= 1");
  end

  joy_state_e state_q, state_d;
  logic [PW-1:0]              phase_q, phase_d;
  logic [4:0]                 bitcnt_q, bitcnt_d;
  logic [FRAME_BITS-1:0]      capture_q, capture_d;
  logic [BITS_PER_PLAYER-1:0] joy1_q, joy2_q;
  logic                       frame_done_q;
  logic                       joy_clk_q;
  logic                       joy_load_q;
  logic                       data_sync;
  logic                       phase_last;
  logic                       accept;
  logic                       commit_upd;

  joy_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (reset),
    .d_i (JOY_DATA),
    .q_o (data_sync)
  );

  assign phase_last = (state_q == ST_GAP_WAIT) ? (phase_q == GAP_LAST)
                                               : (phase_q == DIV_LAST);

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q + 1'b1;
    bitcnt_d  = bitcnt_q;
    capture_d = capture_q;
    case (state_q)
      ST_IDLE:    state_d = ST_LOAD_LO;
      ST_LOAD_LO: if (phase_last) state_d = ST_LOAD_HI;
      ST_LOAD_HI: begin
        if (phase_last) begin
          state_d  = ST_CLK_LO;
          bitcnt_d = '0;
        end
      end
      // Data is active-low on the wire; store it as pressed=1.
      ST_CLK_LO: begin
        if (phase_last) begin
          capture_d[bitcnt_q] = ~data_sync;
          state_d             = ST_CLK_HI;
        end
      end
      ST_CLK_HI: begin
        if (phase_last) begin
          if (bitcnt_q == LAST_BIT) begin
            state_d = ST_COMMIT;
          end else begin
            bitcnt_d = bitcnt_q + 5'd1;
            state_d  = ST_CLK_LO;
          end
        end
      end
      ST_COMMIT:   state_d = ST_GAP_WAIT;
      ST_GAP_WAIT: if (phase_last) state_d = ST_LOAD_LO;
      default:     state_d = ST_IDLE;
    endcase
    if (state_d != state_q) phase_d = '0;
  end

`ifdef JOY_SERIAL_RX_DEBOUNCE_EN
  logic [FRAME_BITS-1:0] cand_q;

  // A frame is only published when it matches the one before it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_q <= '0;
    end else if (state_q == ST_COMMIT) begin
      cand_q <= capture_q;
    end
  end

  assign accept = (capture_q == cand_q);
`else
  assign accept = 1'b1;
`endif

  assign commit_upd = (state_q == ST_COMMIT) && accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      bitcnt_q     <= '0;
      capture_q    <= '0;
      joy1_q       <= '0;
      joy2_q       <= '0;
      frame_done_q <= 1'b0;
      joy_clk_q    <= 1'b0;
      joy_load_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      bitcnt_q     <= bitcnt_d;
      capture_q    <= capture_d;
      frame_done_q <= commit_upd;
      joy_load_q   <= (state_d != ST_LOAD_LO);
      joy_clk_q    <= (state_d == ST_CLK_HI);
      if (commit_upd) begin
        joy1_q <= capture_q[BITS_PER_PLAYER-1:0];
        joy2_q <= capture_q[FRAME_BITS-1:BITS_PER_PLAYER];
      end
    end
  end

  assign JOY_CLK    = joy_clk_q;
  assign JOY_LOAD   = joy_load_q;
  assign joystick1  = player_word(joy1_q);
  assign joystick2  = player_word(joy2_q);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_joy_serial_rx.sv
// tb/tb_joy_serial_rx.sv - randomized self-checking bench with shift-register adapter model
module tb_joy_serial_rx;
  import joy_serial_pkg::*;

  localparam int DIV    = 4;
  localparam int GAP    = 8;
  localparam int PERIOD = 2*DIV + 48*DIV + 1 + GAP;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        JOY_DATA;
  logic        JOY_CLK;
  logic        JOY_LOAD;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic        frame_done;

  always #5 clk = ~clk;

  joy_serial_rx #(.DIV(DIV), .GAP(GAP)) dut (
    .clk        (clk),
    .reset      (reset),
    .JOY_DATA   (JOY_DATA),
    .JOY_CLK    (JOY_CLK),
    .JOY_LOAD   (JOY_LOAD),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .frame_done (frame_done)
  );

  // Adapter: latches the pressed pattern on LOAD low, shifts one bit per JOY_CLK rise.
  logic [23:0] pat_next = '0;
  logic [23:0] shreg = '1;
  logic [4:0]  sh_idx = 5'd24;
  logic        glitch = 1'b0;

  always @(posedge JOY_CLK or negedge JOY_LOAD) begin
    if (!JOY_LOAD) begin
      shreg  = ~pat_next;
      sh_idx = 5'd0;
    end else if (sh_idx != 5'd24) begin
      sh_idx = sh_idx + 5'd1;
    end
  end

  assign JOY_DATA = glitch ? 1'b0 : ((sh_idx < 5'd24) ? shreg[sh_idx] : 1'b1);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  logic [15:0] exp_j1 = '0;
  logic [15:0] exp_j2 = '0;
  int          exp_done = 0;
`ifdef JOY_SERIAL_RX_DEBOUNCE_EN
  logic [23:0] cand = '0;
`endif

  task automatic model_reset();
    exp_j1 = '0;
    exp_j2 = '0;
`ifdef JOY_SERIAL_RX_DEBOUNCE_EN
    cand = '0;
`endif
  endtask

  task automatic model_frame(input logic [23:0] pat);
    logic upd;
`ifdef JOY_SERIAL_RX_DEBOUNCE_EN
    upd  = (pat == cand);
    cand = pat;
`else
    upd = 1'b1;
`endif
    if (upd) begin
      exp_j1 = {4'h0, pat[11:0]};
      exp_j2 = {4'h0, pat[23:12]};
    end
    exp_done = upd ? 1 : 0;
  endtask

  int          m_done, m_load_low, m_clk_rise, m_fall_cyc;
  logic [15:0] m_j1, m_j2;
  bit          m_timeout, m_sneak;

  task automatic wait_load_fall();
    logic prev_load;
    m_timeout = 1'b1;
    prev_load = JOY_LOAD;
    for (int i = 0; i < 2*PERIOD; i++) begin
      @(negedge clk);
      if (prev_load && !JOY_LOAD) begin
        m_timeout = 1'b0;
        break;
      end
      prev_load = JOY_LOAD;
    end
  endtask

  task automatic run_frame(input logic [23:0] pat, input int glitch_at);
    logic        prev_clk;
    logic [15:0] last_j1, last_j2;
    pat_next = pat;
    wait_load_fall();
    if (m_timeout) return;
    m_fall_cyc = cyc;
    m_load_low = 1;
    m_clk_rise = 0;
    m_done     = 0;
    m_sneak    = 1'b0;
    prev_clk   = JOY_CLK;
    last_j1    = joystick1;
    last_j2    = joystick2;
    for (int i = 0; i < PERIOD - 4; i++) begin
      @(negedge clk);
      glitch = (i == glitch_at);
      if (!JOY_LOAD) m_load_low++;
      if (!prev_clk && JOY_CLK) m_clk_rise++;
      if (frame_done) m_done++;
      else if (joystick1 !== last_j1 || joystick2 !== last_j2) m_sneak = 1'b1;
      prev_clk = JOY_CLK;
      last_j1  = joystick1;
      last_j2  = joystick2;
    end
    glitch = 1'b0;
    m_j1 = joystick1;
    m_j2 = joystick2;
    model_frame(pat);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (JOY_LOAD !== 1'b1) $display("FAIL reset_load: got %b expected 1", JOY_LOAD); else n_pass++;
    n_checks++; if (JOY_CLK !== 1'b0) $display("FAIL reset_clk: got %b expected 0", JOY_CLK); else n_pass++;
    n_checks++; if (joystick1 !== 16'h0) $display("FAIL reset_j1: got %h expected 0000", joystick1); else n_pass++;
    n_checks++; if (joystick2 !== 16'h0) $display("FAIL reset_j2: got %h expected 0000", joystick2); else n_pass++;
    n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", frame_done); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_single_button();
    logic [23:0] pat;
    int          first_fall;
    pat = 24'h0;
    pat[BTN_A] = 1'b1;
    for (int f = 0; f < 2; f++) begin
      run_frame(pat, -1);
      n_checks++; if (m_timeout) $display("FAIL single_timeout: no JOY_LOAD fall within %0d cycles", 2*PERIOD); else n_pass++;
      n_checks++; if (m_done !== exp_done) $display("FAIL single_done: got %0d pulses expected %0d", m_done, exp_done); else n_pass++;
      n_checks++; if (m_j1 !== exp_j1) $display("FAIL single_j1: got %h expected %h", m_j1, exp_j1); else n_pass++;
      n_checks++; if (m_j2 !== exp_j2) $display("FAIL single_j2: got %h expected %h", m_j2, exp_j2); else n_pass++;
      n_checks++; if (m_load_low !== DIV) $display("FAIL load_low_cycles: got %0d expected %0d", m_load_low, DIV); else n_pass++;
      n_checks++; if (m_clk_rise !== 24) $display("FAIL clk_rises: got %0d expected 24", m_clk_rise); else n_pass++;
      n_checks++; if (m_sneak) $display("FAIL single_atomic: got output change without frame_done expected none"); else n_pass++;
      if (f == 0) first_fall = m_fall_cyc;
    end
    n_checks++;
    if (m_fall_cyc - first_fall !== PERIOD)
      $display("FAIL frame_period: got %0d expected %0d", m_fall_cyc - first_fall, PERIOD);
    else n_pass++;
  endtask

  task automatic test_all_pressed();
    for (int f = 0; f < 2; f++) begin
      run_frame(24'hFFFFFF, -1);
      n_checks++; if (m_timeout) $display("FAIL all_timeout: no JOY_LOAD fall"); else n_pass++;
      n_checks++; if (m_done !== exp_done) $display("FAIL all_done: got %0d expected %0d", m_done, exp_done); else n_pass++;
      n_checks++; if (m_j1 !== exp_j1) $display("FAIL all_j1: got %h expected %h", m_j1, exp_j1); else n_pass++;
      n_checks++; if (m_j2 !== exp_j2) $display("FAIL all_j2: got %h expected %h", m_j2, exp_j2); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [23:0] p;
    for (int n = 0; n < 4; n++) begin
      p = 24'($urandom);
      for (int f = 0; f < 2; f++) begin
        run_frame(p, -1);
        n_checks++; if (m_timeout) $display("FAIL rand_timeout: no JOY_LOAD fall"); else n_pass++;
        n_checks++; if (m_done !== exp_done) $display("FAIL rand_done: got %0d expected %0d pat %h", m_done, exp_done, p); else n_pass++;
        n_checks++; if (m_j1 !== exp_j1) $display("FAIL rand_j1: got %h expected %h pat %h", m_j1, exp_j1, p); else n_pass++;
        n_checks++; if (m_j2 !== exp_j2) $display("FAIL rand_j2: got %h expected %h pat %h", m_j2, exp_j2, p); else n_pass++;
        n_checks++; if (m_sneak) $display("FAIL rand_atomic: got output change without frame_done expected none"); else n_pass++;
      end
    end
  endtask

  task automatic test_toggle();
    logic [23:0] up2;
    logic [23:0] seq [6];
    up2 = 24'h0;
    up2[BITS_PER_PLAYER + BTN_UP] = 1'b1;
    seq = '{up2, 24'h0, up2, 24'h0, up2, up2};
    for (int f = 0; f < 6; f++) begin
      run_frame(seq[f], -1);
      n_checks++; if (m_timeout) $display("FAIL toggle_timeout: no JOY_LOAD fall"); else n_pass++;
      n_checks++; if (m_done !== exp_done) $display("FAIL toggle_done: got %0d expected %0d frame %0d", m_done, exp_done, f); else n_pass++;
      n_checks++; if (m_j2 !== exp_j2) $display("FAIL toggle_j2: got %h expected %h frame %0d", m_j2, exp_j2, f); else n_pass++;
      n_checks++; if (m_j1 !== exp_j1) $display("FAIL toggle_j1: got %h expected %h frame %0d", m_j1, exp_j1, f); else n_pass++;
    end
  endtask

  task automatic test_glitch();
    logic [23:0] p;
    int          k;
    p = 24'($urandom);
    for (int f = 0; f < 2; f++) begin
      k = int'($urandom_range(22, 0));
      run_frame(p, 12 + 8*k);
      n_checks++; if (m_timeout) $display("FAIL glitch_timeout: no JOY_LOAD fall"); else n_pass++;
      n_checks++; if (m_j1 !== exp_j1) $display("FAIL glitch_j1: got %h expected %h bit %0d", m_j1, exp_j1, k); else n_pass++;
      n_checks++; if (m_j2 !== exp_j2) $display("FAIL glitch_j2: got %h expected %h bit %0d", m_j2, exp_j2, k); else n_pass++;
      n_checks++; if (m_done !== exp_done) $display("FAIL glitch_done: got %0d expected %0d", m_done, exp_done); else n_pass++;
    end
  endtask

  task automatic test_reset_midframe();
    logic [23:0] pat_a, pat_b;
    pat_a = 24'($urandom) | 24'h000801;
    pat_b = (24'($urandom) | 24'h001000) & ~pat_a;
    run_frame(pat_a, -1);
    run_frame(pat_a, -1);
    n_checks++; if (joystick1 === 16'h0 && joystick2 === 16'h0) $display("FAIL midrst_setup: got 0000/0000 expected nonzero outputs"); else n_pass++;
    pat_next = pat_a;
    wait_load_fall();
    n_checks++; if (m_timeout) $display("FAIL midrst_timeout: no JOY_LOAD fall"); else n_pass++;
    repeat (2*DIV + 10*2*DIV + 2) @(negedge clk);
    n_checks++; if (JOY_CLK !== 1'b0) $display("FAIL midrst_pre_clk: got %b expected 0 in bit 10 low phase", JOY_CLK); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if (JOY_LOAD !== 1'b1) $display("FAIL midrst_load: got %b expected 1", JOY_LOAD); else n_pass++;
    n_checks++; if (JOY_CLK !== 1'b0) $display("FAIL midrst_clk: got %b expected 0", JOY_CLK); else n_pass++;
    n_checks++; if (joystick1 !== 16'h0) $display("FAIL midrst_j1: got %h expected 0000", joystick1); else n_pass++;
    n_checks++; if (joystick2 !== 16'h0) $display("FAIL midrst_j2: got %h expected 0000", joystick2); else n_pass++;
    n_checks++; if (frame_done !== 1'b0) $display("FAIL midrst_done: got %b expected 0", frame_done); else n_pass++;
    model_reset();
    repeat (3) @(negedge clk);
    pat_next = pat_b;
    reset = 1'b0;
    for (int f = 0; f < 2; f++) begin
      run_frame(pat_b, -1);
      n_checks++; if (m_timeout) $display("FAIL post_timeout: no JOY_LOAD fall"); else n_pass++;
      n_checks++; if (m_done !== exp_done) $display("FAIL post_done: got %0d expected %0d", m_done, exp_done); else n_pass++;
      n_checks++; if (m_j1 !== exp_j1) $display("FAIL post_j1: got %h expected %h", m_j1, exp_j1); else n_pass++;
      n_checks++; if (m_j2 !== exp_j2) $display("FAIL post_j2: got %h expected %h", m_j2, exp_j2); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_button();
    test_all_pressed();
    test_random();
    test_toggle();
    test_glitch();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
